// File: rtl/pc_stack.sv
// Fetch-stage program counter with stall, relative/absolute jumps
// and a flop-based return-address stack with sticky error flags.
module pc_stack #(
    parameter int           D           = 12,
    parameter int           STACK_DEPTH = 4,
    parameter logic [D-1:0] RESET_ADDR  = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             reljump_en,
    input  logic                             absjump_en,
    input  logic                             call_en,
    input  logic                             ret_en,
    input  logic [D-1:0]                     target,
    output logic [D-1:0]                     prog_ctr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [D-1:0]   r_pc;
    logic [SPW-1:0] r_sp;
    logic           r_ovf;
    logic           r_unf;
    logic [D-1:0]   r_stack [STACK_DEPTH];

    logic [D-1:0]   w_pc_nxt;
    logic [D-1:0]   w_pc_inc;
    logic [SPW-1:0] w_sp_nxt;
    logic           w_ovf_nxt;
    logic           w_unf_nxt;
    logic           w_push;
    logic           w_full;
    logic           w_empty;
    logic [AW-1:0]  w_wr_idx;
    logic [AW-1:0]  w_rd_idx;

    assign w_full   = (r_sp == SPW'(STACK_DEPTH));
    assign w_empty  = (r_sp == '0);
    assign w_pc_inc = r_pc + D'(1);
    assign w_wr_idx = AW'(r_sp);
    assign w_rd_idx = AW'(r_sp - SPW'(1));

    always_comb begin
        w_pc_nxt  = r_pc;
        w_sp_nxt  = r_sp;
        w_ovf_nxt = r_ovf;
        w_unf_nxt = r_unf;
        w_push    = 1'b0;
        if (!stall) begin
            if (ret_en) begin
                if (w_empty) begin
                    w_pc_nxt  = w_pc_inc;
                    w_unf_nxt = 1'b1;
                end else begin
                    w_pc_nxt = r_stack[w_rd_idx];
                    w_sp_nxt = r_sp - SPW'(1);
                end
            end else if (call_en) begin
                // a full stack still takes the jump, only the push is lost
                w_pc_nxt = target;
                if (w_full) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_push   = 1'b1;
                    w_sp_nxt = r_sp + SPW'(1);
                end
            end else if (reljump_en) begin
                w_pc_nxt = r_pc + target;
            end else if (absjump_en) begin
                w_pc_nxt = target;
            end else begin
                w_pc_nxt = w_pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_ADDR;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_sp  <= w_sp_nxt;
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign prog_ctr    = r_pc;
    assign sp          = r_sp;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: a reference model queues the expected
// state per driven cycle; it is popped and compared after each edge.
module tb_pc_stack;

    localparam int D     = 12;
    localparam int DEPTH = 4;
    localparam logic [D-1:0] RADDR = 12'h000;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         reljump_en;
    logic         absjump_en;
    logic         call_en;
    logic         ret_en;
    logic [D-1:0] target;
    logic [D-1:0] prog_ctr;
    logic [2:0]   sp;
    logic         stack_full;
    logic         stack_empty;
    logic         overflow;
    logic         underflow;

    typedef struct {
        logic [D-1:0] pc;
        int           sp;
        logic         ovf;
        logic         unf;
    } exp_t;

    exp_t         sb_q[$];
    logic [D-1:0] m_pc;
    int           m_sp;
    logic [D-1:0] m_stk [DEPTH];
    logic         m_ovf;
    logic         m_unf;
    int           n_checks;
    int           n_errors;

    pc_stack #(
        .D(D),
        .STACK_DEPTH(DEPTH),
        .RESET_ADDR(RADDR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .reljump_en(reljump_en),
        .absjump_en(absjump_en),
        .call_en(call_en),
        .ret_en(ret_en),
        .target(target),
        .prog_ctr(prog_ctr),
        .sp(sp),
        .stack_full(stack_full),
        .stack_empty(stack_empty),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic rs, input logic st, input logic rl,
                         input logic ab, input logic ca, input logic re,
                         input logic [D-1:0] tg);
        exp_t e;
        if (rs) begin
            m_pc  = RADDR;
            m_sp  = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!st) begin
            if (re) begin
                if (m_sp == 0) begin
                    m_pc  = m_pc + 12'd1;
                    m_unf = 1'b1;
                end else begin
                    m_sp = m_sp - 1;
                    m_pc = m_stk[m_sp];
                end
            end else if (ca) begin
                if (m_sp == DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    m_stk[m_sp] = m_pc + 12'd1;
                    m_sp        = m_sp + 1;
                end
                m_pc = tg;
            end else if (rl) begin
                m_pc = m_pc + tg;
            end else if (ab) begin
                m_pc = tg;
            end else begin
                m_pc = m_pc + 12'd1;
            end
        end
        e.pc  = m_pc;
        e.sp  = m_sp;
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic rs, input logic st, input logic rl,
                        input logic ab, input logic ca, input logic re,
                        input logic [D-1:0] tg);
        exp_t e;
        reset      = rs;
        stall      = st;
        reljump_en = rl;
        absjump_en = ab;
        call_en    = ca;
        ret_en     = re;
        target     = tg;
        model(rs, st, rl, ab, ca, re, tg);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("pc", 32'(prog_ctr), 32'(e.pc));
            check("sp", 32'(sp), 32'(e.sp));
            check("full", 32'(stack_full), 32'(e.sp == DEPTH));
            check("empty", 32'(stack_empty), 32'(e.sp == 0));
            check("ovf", 32'(overflow), 32'(e.ovf));
            check("unf", 32'(underflow), 32'(e.unf));
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 12'h000);
    endtask

    task automatic call(input logic [D-1:0] tg);
        step(0, 0, 0, 0, 1, 0, tg);
    endtask

    task automatic ret();
        step(0, 0, 0, 0, 0, 1, 12'h000);
    endtask

    task automatic jmp(input logic [D-1:0] tg);
        step(0, 0, 0, 1, 0, 0, tg);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_pc     = RADDR;
        m_sp     = 0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;

        step(1, 0, 0, 0, 0, 0, 12'h000);
        step(1, 0, 0, 0, 0, 0, 12'h000);
        check("rst_pc", 32'(prog_ctr), 32'h0);
        check("rst_empty", 32'(stack_empty), 32'd1);
        for (int i = 0; i < 5; i++) idle();
        check("idle5_pc", 32'(prog_ctr), 32'h5);

        jmp(12'hFFE);
        idle();
        check("wrap_fff", 32'(prog_ctr), 32'hFFF);
        idle();
        check("wrap_000", 32'(prog_ctr), 32'h000);

        jmp(12'h010);
        call(12'h100);
        check("call1_sp", 32'(sp), 32'd1);
        idle();
        idle();
        call(12'h200);
        check("call2_pc", 32'(prog_ctr), 32'h200);
        ret();
        check("ret1_pc", 32'(prog_ctr), 32'h103);
        ret();
        check("ret2_pc", 32'(prog_ctr), 32'h011);

        for (int i = 0; i < 5; i++) call(12'h300 + 12'(i));
        check("ovf_pc", 32'(prog_ctr), 32'h304);
        check("ovf_flag", 32'(overflow), 32'd1);
        ret();
        check("pop_303", 32'(prog_ctr), 32'h303);
        ret();
        ret();
        ret();
        check("pop_last", 32'(prog_ctr), 32'h012);
        ret();
        check("unf_pc", 32'(prog_ctr), 32'h013);
        check("unf_flag", 32'(underflow), 32'd1);

        step(1, 0, 0, 0, 0, 0, 12'h000);
        jmp(12'h050);
        step(0, 0, 0, 1, 1, 1, 12'h0AA);
        check("prio_pc", 32'(prog_ctr), 32'h051);
        check("prio_unf", 32'(underflow), 32'd1);
        step(0, 1, 0, 1, 0, 0, 12'h0AA);
        check("stall_pc", 32'(prog_ctr), 32'h051);

        jmp(12'h020);
        step(0, 0, 1, 0, 0, 0, 12'hFFC);
        check("relback_pc", 32'(prog_ctr), 32'h01C);
        call(12'h040);
        step(1, 0, 0, 0, 1, 0, 12'h080);
        check("rstmid_pc", 32'(prog_ctr), 32'(RADDR));
        check("rstmid_sp", 32'(sp), 32'd0);

        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), 12'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

endmodule
